// File: rtl/sha_job_scheduler.sv
// rtl/sha_job_scheduler.sv - round-robin dispatch of a batch of SHA-256 jobs across NUM_CORES hash cores
module sha_job_scheduler #(
    parameter int NUM_CORES  = 4,
    parameter int MSG_STRIDE = 20,
    parameter int OUT_STRIDE = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [7:0]              num_jobs,
    input  logic [15:0]             message_base,
    input  logic [15:0]             output_base,
    output logic [NUM_CORES-1:0]    core_start,
    output logic [16*NUM_CORES-1:0] core_message_addr,
    output logic [16*NUM_CORES-1:0] core_output_addr,
    input  logic [NUM_CORES-1:0]    core_done,
    output logic                    busy,
    output logic                    done,
    output logic [7:0]              jobs_completed
);

    localparam logic [3:0]  NC       = 4'(NUM_CORES);
    localparam logic [15:0] MSG_STEP = 16'(MSG_STRIDE);
    localparam logic [15:0] OUT_STEP = 16'(OUT_STRIDE);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} top_state_t;
    typedef enum logic [1:0] {SL_FREE, SL_LAUNCH, SL_ARMED, SL_RUN} slot_state_t;

    top_state_t  state;
    slot_state_t slot [NUM_CORES];

    logic [7:0]  num_jobs_q;
    logic [7:0]  issued;
    logic [15:0] msg_next;
    logic [15:0] out_next;
    logic [3:0]  rr_ptr;
    logic [3:0]  winner;
    logic [3:0]  idx;
    logic [3:0]  n_complete;
    logic        launch;
    logic        all_free;

    assign busy = (state == ST_RUN);

    // Round-robin search from rr_ptr; first free core reporting idle wins.
    always_comb begin
        launch     = 1'b0;
        winner     = '0;
        idx        = '0;
        all_free   = 1'b1;
        n_complete = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (slot[i] != SL_FREE) all_free = 1'b0;
            if (slot[i] == SL_RUN && core_done[i]) n_complete = n_complete + 4'd1;
        end
        if (state == ST_RUN && issued != num_jobs_q) begin
            for (int k = 0; k < NUM_CORES; k++) begin
                idx = rr_ptr + 4'(k);
                if (idx >= NC) idx = idx - NC;
                for (int i = 0; i < NUM_CORES; i++) begin
                    if (!launch && 4'(i) == idx && slot[i] == SL_FREE && core_done[i]) begin
                        launch = 1'b1;
                        winner = idx;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ST_IDLE;
            core_start        <= '0;
            core_message_addr <= '0;
            core_output_addr  <= '0;
            done              <= 1'b0;
            jobs_completed    <= '0;
            issued            <= '0;
            rr_ptr            <= '0;
            num_jobs_q        <= '0;
            msg_next          <= '0;
            out_next          <= '0;
            for (int i = 0; i < NUM_CORES; i++) slot[i] <= SL_FREE;
        end else begin
            done           <= 1'b0;
            core_start     <= '0;
            jobs_completed <= jobs_completed + {4'b0, n_complete};

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        num_jobs_q     <= num_jobs;
                        msg_next       <= message_base;
                        out_next       <= output_base;
                        issued         <= '0;
                        rr_ptr         <= '0;
                        jobs_completed <= '0;
                        state          <= (num_jobs == 8'd0) ? ST_FIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (issued == num_jobs_q && all_free) state <= ST_FIN;
                end
                ST_FIN: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            // Running address accumulators replace a per-job multiply.
            if (launch) begin
                issued   <= issued + 8'd1;
                msg_next <= msg_next + MSG_STEP;
                out_next <= out_next + OUT_STEP;
                rr_ptr   <= (winner + 4'd1 == NC) ? 4'd0 : winner + 4'd1;
            end

            for (int i = 0; i < NUM_CORES; i++) begin
                case (slot[i])
                    SL_FREE: begin
                        if (launch && winner == 4'(i)) begin
                            slot[i]                      <= SL_LAUNCH;
                            core_start[i]                <= 1'b1;
                            core_message_addr[16*i +: 16] <= msg_next;
                            core_output_addr[16*i +: 16]  <= out_next;
                        end
                    end
                    SL_LAUNCH: slot[i] <= SL_ARMED;
                    SL_ARMED:  if (!core_done[i]) slot[i] <= SL_RUN;
                    SL_RUN:    if (core_done[i]) slot[i] <= SL_FREE;
                    default:   slot[i] <= SL_FREE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sha_job_scheduler.sv
// tb/tb_sha_job_scheduler.sv - directed vector bench for sha_job_scheduler with behavioural hash cores
module tb_sha_job_scheduler;

    localparam int NC = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [7:0]      num_jobs;
    logic [15:0]     message_base;
    logic [15:0]     output_base;
    logic [NC-1:0]   core_start;
    logic [16*NC-1:0] core_message_addr;
    logic [16*NC-1:0] core_output_addr;
    logic [NC-1:0]   core_done;
    logic            busy;
    logic            done;
    logic [7:0]      jobs_completed;

    sha_job_scheduler #(.NUM_CORES(NC), .MSG_STRIDE(20), .OUT_STRIDE(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .num_jobs          (num_jobs),
        .message_base      (message_base),
        .output_base       (output_base),
        .core_start        (core_start),
        .core_message_addr (core_message_addr),
        .core_output_addr  (core_output_addr),
        .core_done         (core_done),
        .busy              (busy),
        .done              (done),
        .jobs_completed    (jobs_completed)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Hash core model: done drops on the start pulse and rises lat cycles later.
    int   lat [NC];
    int   cnt [NC];
    logic core_clear;

    always @(negedge clk) begin
        for (int i = 0; i < NC; i++) begin
            if (core_clear) begin
                cnt[i]       = 0;
                core_done[i] = 1'b1;
            end else if (core_start[i]) begin
                cnt[i]       = lat[i];
                core_done[i] = 1'b0;
            end else if (cnt[i] > 0) begin
                cnt[i] = cnt[i] - 1;
                if (cnt[i] == 0) core_done[i] = 1'b1;
            end
        end
    end

    int          nl       = 0;
    int          l_core [64];
    int          l_cyc  [64];
    logic [15:0] l_msg  [64];
    logic [15:0] l_out  [64];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          overlap  = 0;
    int          two_cnt  = 0;
    logic [7:0]  prev_jc  = 8'd0;

    always @(negedge clk) begin
        for (int i = 0; i < NC; i++) begin
            if (core_start[i] === 1'b1 && nl < 64) begin
                l_core[nl] = i;
                l_cyc[nl]  = cyc;
                l_msg[nl]  = core_message_addr[16*i +: 16];
                l_out[nl]  = core_output_addr[16*i +: 16];
                nl         = nl + 1;
            end
        end
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (busy === 1'b1 && done === 1'b1) overlap = overlap + 1;
        if (int'(jobs_completed) - int'(prev_jc) == 2) two_cnt = two_cnt + 1;
        prev_jc = jobs_completed;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_lat(input int a, input int b, input int c, input int d);
        lat[0] = a; lat[1] = b; lat[2] = c; lat[3] = d;
    endtask

    task automatic run_batch(input logic [7:0] n, input logic [15:0] mb, input logic [15:0] ob,
                             output int st_cyc);
        int dc0;
        int t;
        dc0          = done_cnt;
        num_jobs     = n;
        message_base = mb;
        output_base  = ob;
        start        = 1'b1;
        st_cyc       = cyc;
        tick(1);
        start = 1'b0;
        t = 0;
        while (done_cnt == dc0 && t < 3000) begin
            tick(1);
            t++;
        end
        chk("batch_timeout", int'(t < 3000), 1);
        tick(3);
    endtask

    typedef struct {
        logic [7:0]  n;
        logic [15:0] mb;
        logic [15:0] ob;
        int          l0, l1, l2, l3;
        logic [15:0] exp_msg;
        logic [15:0] exp_out;
    } vec_t;

    vec_t tv [5];
    int   st, nl0, dc0, tw0;

    initial begin
        tv[0] = '{8'd6, 16'h0000, 16'h0100, 100, 100, 100, 100, 16'h0064, 16'h0128};
        tv[1] = '{8'd2, 16'hFFF0, 16'h0000, 7, 7, 7, 7, 16'h0004, 16'h0008};
        tv[2] = '{8'd1, 16'h1234, 16'hABCD, 3, 3, 3, 3, 16'h1234, 16'hABCD};
        tv[3] = '{8'd9, 16'h0010, 16'hFFFC, 5, 7, 3, 9, 16'h00B0, 16'h003C};
        tv[4] = '{8'd0, 16'h5555, 16'h6666, 4, 4, 4, 4, 16'h0000, 16'h0000};

        set_lat(100, 100, 100, 100);
        core_clear   = 1'b1;
        reset        = 1'b1;
        start        = 1'b1;
        num_jobs     = 8'd5;
        message_base = 16'h1000;
        output_base  = 16'h2000;
        tick(2);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_core_start", int'(core_start), 0);
        chk("rst_jobs_completed", int'(jobs_completed), 0);
        reset      = 1'b0;
        start      = 1'b0;
        core_clear = 1'b0;
        tick(5);
        chk("rst_nothing_latched_busy", int'(busy), 0);
        chk("rst_nothing_latched_launches", nl, 0);

        // Zero-job batch: done two cycles after start, no launches.
        nl0 = nl; dc0 = done_cnt;
        run_batch(8'd0, 16'h0000, 16'h0000, st);
        chk("zero_done_latency", done_cyc - st, 2);
        chk("zero_launches", nl - nl0, 0);
        chk("zero_jobs_completed", int'(jobs_completed), 0);
        chk("zero_done_once", done_cnt - dc0, 1);

        for (int v = 0; v < 5; v++) begin
            set_lat(tv[v].l0, tv[v].l1, tv[v].l2, tv[v].l3);
            nl0 = nl; dc0 = done_cnt;
            run_batch(tv[v].n, tv[v].mb, tv[v].ob, st);
            chk($sformatf("v%0d_done_once", v), done_cnt - dc0, 1);
            chk($sformatf("v%0d_launches", v), nl - nl0, int'(tv[v].n));
            chk($sformatf("v%0d_jobs_completed", v), int'(jobs_completed), int'(tv[v].n));
            chk($sformatf("v%0d_busy_after", v), int'(busy), 0);
            if (nl > nl0) begin
                chk($sformatf("v%0d_last_msg", v), int'(l_msg[nl-1]), int'(tv[v].exp_msg));
                chk($sformatf("v%0d_last_out", v), int'(l_out[nl-1]), int'(tv[v].exp_out));
                chk($sformatf("v%0d_first_msg", v), int'(l_msg[nl0]), int'(tv[v].mb));
                chk($sformatf("v%0d_first_latency", v), l_cyc[nl0] - st, 2);
            end
            if (v == 0) begin
                for (int j = 0; j < 4; j++) begin
                    chk($sformatf("v0_job%0d_core", j), l_core[nl0+j], j);
                    chk($sformatf("v0_job%0d_cycle", j), l_cyc[nl0+j] - l_cyc[nl0], j);
                end
                chk("v0_job4_core", l_core[nl0+4], 0);
                chk("v0_job5_core", l_core[nl0+5], 1);
                chk("v0_relaunch_gap", l_cyc[nl0+4] - l_cyc[nl0], 102);
            end
        end

        // Cores 1 and 3 finish on the same cycle.
        set_lat(10, 20, 30, 18);
        nl0 = nl; dc0 = done_cnt; tw0 = two_cnt;
        run_batch(8'd4, 16'h0000, 16'h0000, st);
        chk("pair_increment_by_two", two_cnt - tw0, 1);
        chk("pair_jobs_completed", int'(jobs_completed), 4);
        chk("pair_done_once", done_cnt - dc0, 1);

        // Reset while three cores are busy, then a clean batch.
        set_lat(100, 100, 100, 100);
        nl0 = nl; dc0 = done_cnt;
        num_jobs     = 8'd3;
        message_base = 16'h0000;
        output_base  = 16'h0040;
        start        = 1'b1;
        tick(1);
        start = 1'b0;
        tick(12);
        chk("mid_launches_before_reset", nl - nl0, 3);
        chk("mid_busy_before_reset", int'(busy), 1);
        reset = 1'b1;
        tick(1);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_jobs_completed", int'(jobs_completed), 0);
        chk("mid_rst_core_start", int'(core_start), 0);
        chk("mid_rst_msg_addr", int'(core_message_addr[31:16]), 0);
        chk("mid_rst_out_addr", int'(core_output_addr[15:0]), 0);
        reset      = 1'b0;
        core_clear = 1'b1;
        tick(1);
        core_clear = 1'b0;
        tick(2);
        chk("mid_no_done_after_reset", done_cnt - dc0, 0);
        set_lat(4, 4, 4, 4);
        nl0 = nl; dc0 = done_cnt;
        run_batch(8'd5, 16'h0200, 16'h0300, st);
        chk("fresh_launches", nl - nl0, 5);
        chk("fresh_first_core", l_core[nl0], 0);
        chk("fresh_last_msg", int'(l_msg[nl-1]), 16'h0250);
        chk("fresh_last_out", int'(l_out[nl-1]), 16'h0320);
        chk("fresh_jobs_completed", int'(jobs_completed), 5);
        chk("fresh_done_once", done_cnt - dc0, 1);

        chk("busy_done_overlap", overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
